urv_irq_ctrl: RTL and testbench

- Interrupt aggregator directly upstream of the exception unit.
- Synchronises NUM_IRQS asynchronous external interrupt lines and latches them per line as edge- or level-sensitive.
- Masks them with an enable register and drives the single exp_irq level consumed by the exception unit.
- Software reaches its registers through a small word-addressed register port and reads the winning interrupt ID from a claim register.

---
 rtl/urv_irq_ctrl_if.sv | 27 ++
 rtl/urv_irq_ctrl.sv | 136 +++++++++++++
 tb/tb_urv_irq_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/urv_irq_ctrl_if.sv
// Register-port bundle between software-facing bus logic and urv_irq_ctrl.
interface urv_irq_ctrl_if;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] reg_addr_i;
  logic              reg_we_i;
  logic              reg_re_i;
  logic [DATA_W-1:0] reg_wdata_i;
  logic [DATA_W-1:0] reg_rdata_o;

  modport master (
    output reg_addr_i,
    output reg_we_i,
    output reg_re_i,
    output reg_wdata_i,
    input  reg_rdata_o
  );

  modport slave (
    input  reg_addr_i,
    input  reg_we_i,
    input  reg_re_i,
    input  reg_wdata_i,
    output reg_rdata_o
  );
endinterface

// File: rtl/urv_irq_ctrl.sv
// Interrupt aggregator: synchronises, latches (edge/level), masks and prioritises external IRQs.
// Optional macro URV_IRQ_CTRL_CLAIM_CLEAR_EN: a CLAIM read clears the claimed edge-type line.
module urv_irq_ctrl #(
  parameter int unsigned NUM_IRQS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_IRQS-1:0] irq_i,
  urv_irq_ctrl_if.slave       reg_bus,
  output logic                exp_irq_o,
  output logic [4:0]          irq_id_o
);

  localparam int unsigned ID_W   = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_EDGE    = 2'd2;
  localparam logic [1:0] ADDR_CLAIM   = 2'd3;

  logic [SYNC_STAGES-1:0][NUM_IRQS-1:0] sync_q, sync_d;
  logic [NUM_IRQS-1:0] sync_dly_q, sync_dly_d;
  logic [NUM_IRQS-1:0] pending_q, pending_d;
  logic [NUM_IRQS-1:0] enable_q, enable_d;
  logic [NUM_IRQS-1:0] edge_q, edge_d;
  logic                exp_irq_q, exp_irq_d;
  logic [ID_W-1:0]     irq_id_q, irq_id_d;

  logic [NUM_IRQS-1:0] sync_c, rise_c, active_c, w1c_c, claim_clr_c;
  logic [ID_W-1:0]     claim_id_c;
  logic                any_active_c;
  logic                wr_pending_c, wr_enable_c, wr_edge_c;
  logic                unused_bits_c;

  // Upper write-data bits and (in the default build) the read strobe carry no function
  assign unused_bits_c = ^{reg_bus.reg_wdata_i[DATA_W-1:NUM_IRQS], reg_bus.reg_re_i};

  assign wr_pending_c = reg_bus.reg_we_i && (reg_bus.reg_addr_i == ADDR_PENDING);
  assign wr_enable_c  = reg_bus.reg_we_i && (reg_bus.reg_addr_i == ADDR_ENABLE);
  assign wr_edge_c    = reg_bus.reg_we_i && (reg_bus.reg_addr_i == ADDR_EDGE);

  // Input synchroniser chain and one-cycle delayed copy for rise detection
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = irq_i;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    sync_c     = sync_q[SYNC_STAGES-1];
    sync_dly_d = sync_c;
    rise_c     = sync_c & ~sync_dly_q;
  end

  assign active_c     = pending_q & enable_q;
  assign any_active_c = |active_c;

  // Lowest-numbered active line wins
  always_comb begin
    claim_id_c = '0;
    for (int n = int'(NUM_IRQS) - 1; n >= 0; n--) begin
      if (active_c[n]) claim_id_c = ID_W'(n);
    end
  end

  always_comb begin
    claim_clr_c = '0;
`ifdef URV_IRQ_CTRL_CLAIM_CLEAR_EN
    for (int n = 0; n < int'(NUM_IRQS); n++) begin
      claim_clr_c[n] = reg_bus.reg_re_i && (reg_bus.reg_addr_i == ADDR_CLAIM) &&
                       any_active_c && (claim_id_c == ID_W'(n));
    end
`endif
  end

  assign w1c_c = wr_pending_c ? reg_bus.reg_wdata_i[NUM_IRQS-1:0] : '0;

  // Edge lines: sticky with clear, a same-cycle rise wins; level lines follow the input
  always_comb begin
    pending_d = pending_q;
    for (int n = 0; n < int'(NUM_IRQS); n++) begin
      if (edge_q[n]) begin
        pending_d[n] = (pending_q[n] & ~w1c_c[n] & ~claim_clr_c[n]) | rise_c[n];
      end else begin
        pending_d[n] = sync_c[n];
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    if (wr_enable_c) enable_d = reg_bus.reg_wdata_i[NUM_IRQS-1:0];
    if (wr_edge_c)   edge_d   = reg_bus.reg_wdata_i[NUM_IRQS-1:0];
  end

  assign exp_irq_d = any_active_c;
  assign irq_id_d  = claim_id_c;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q     <= '0;
      sync_dly_q <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      edge_q     <= '0;
      exp_irq_q  <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edge_q     <= edge_d;
      exp_irq_q  <= exp_irq_d;
      irq_id_q   <= irq_id_d;
    end
  end

  // Read mux sees register state before any same-cycle write lands
  always_comb begin
    reg_bus.reg_rdata_o = '0;
    case (reg_bus.reg_addr_i)
      ADDR_PENDING: reg_bus.reg_rdata_o = DATA_W'(pending_q);
      ADDR_ENABLE:  reg_bus.reg_rdata_o = DATA_W'(enable_q);
      ADDR_EDGE:    reg_bus.reg_rdata_o = DATA_W'(edge_q);
      ADDR_CLAIM:   reg_bus.reg_rdata_o = {any_active_c, 26'd0, claim_id_c};
      default:      reg_bus.reg_rdata_o = '0;
    endcase
  end

  assign exp_irq_o = exp_irq_q;
  assign irq_id_o  = irq_id_q;

endmodule

// File: tb/tb_urv_irq_ctrl.sv
// Directed self-checking bench for urv_irq_ctrl (NUM_IRQS=8, SYNC_STAGES=2).
module tb_urv_irq_ctrl;
  logic       clk;
  logic       rst_n;
  logic [7:0] irq;
  logic       exp_irq;
  logic [4:0] irq_id;
  int         n_tests;
  int         n_fail;

  urv_irq_ctrl_if bus();

  urv_irq_ctrl #(.NUM_IRQS(8), .SYNC_STAGES(2)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .irq_i    (irq),
    .reg_bus  (bus),
    .exp_irq_o(exp_irq),
    .irq_id_o (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.reg_addr_i  = addr;
    bus.reg_wdata_i = data;
    bus.reg_we_i    = 1'b1;
    @(negedge clk);
    bus.reg_we_i    = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    bus.reg_addr_i = addr;
    #1;
    check(tag, bus.reg_rdata_o, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    irq     = '0;
    bus.reg_addr_i  = '0;
    bus.reg_we_i    = 1'b0;
    bus.reg_re_i    = 1'b0;
    bus.reg_wdata_i = '0;
    step(3);
    check("rst_exp_irq", 32'(exp_irq), 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    rd_check("rst_pending", 2'd0, 32'h0);
    rd_check("rst_enable", 2'd1, 32'h0);
    rd_check("rst_claim", 2'd3, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Edge line 0: latency and W1C
    wr(2'd2, 32'h01);
    wr(2'd1, 32'h01);
    irq[0] = 1'b1;
    step(2);
    rd_check("e0_pend_edge2", 2'd0, 32'h00);
    step(1);
    irq[0] = 1'b0;
    rd_check("e0_pend_edge3", 2'd0, 32'h01);
    check("e0_exp_edge3", 32'(exp_irq), 32'd0);
    step(1);
    check("e0_exp_edge4", 32'(exp_irq), 32'd1);
    check("e0_id", 32'(irq_id), 32'd0);
    rd_check("e0_claim", 2'd3, 32'h8000_0000);
    wr(2'd0, 32'h01);
    rd_check("e0_pend_clr", 2'd0, 32'h00);
    step(1);
    check("e0_exp_clr", 32'(exp_irq), 32'd0);

    // Level line 5
    wr(2'd1, 32'h20);
    irq[5] = 1'b1;
    step(3);
    rd_check("l5_pend", 2'd0, 32'h20);
    step(1);
    check("l5_exp", 32'(exp_irq), 32'd1);
    check("l5_id", 32'(irq_id), 32'd5);
    wr(2'd0, 32'h20);
    rd_check("l5_w1c_noeff", 2'd0, 32'h20);
    irq[5] = 1'b0;
    step(3);
    check("l5_exp_still", 32'(exp_irq), 32'd1);
    step(1);
    check("l5_exp_drop", 32'(exp_irq), 32'd0);
    rd_check("l5_pend_drop", 2'd0, 32'h00);

    // Priority among edge lines 2 and 6
    wr(2'd2, 32'h45);
    wr(2'd1, 32'hFFFF_FFFF);
    rd_check("en_mask", 2'd1, 32'h0000_00FF);
    rd_check("edge_rd", 2'd2, 32'h0000_0045);
    irq[2] = 1'b1;
    irq[6] = 1'b1;
    step(4);
    irq[2] = 1'b0;
    irq[6] = 1'b0;
    rd_check("p_pend", 2'd0, 32'h44);
    rd_check("p_claim2", 2'd3, 32'h8000_0002);
    check("p_id2", 32'(irq_id), 32'd2);
    wr(2'd3, 32'h0);
    rd_check("p_claim_wr_ign", 2'd3, 32'h8000_0002);
    wr(2'd0, 32'h04);
    rd_check("p_claim6", 2'd3, 32'h8000_0006);
    step(1);
    check("p_id6", 32'(irq_id), 32'd6);
    wr(2'd1, 32'h00);
    rd_check("p_claim_masked", 2'd3, 32'h0000_0000);
    step(1);
    check("p_exp_masked", 32'(exp_irq), 32'd0);
    check("p_id_masked", 32'(irq_id), 32'd0);
    wr(2'd0, 32'hFF);
    rd_check("p_pend_clr", 2'd0, 32'h00);

    // Rise on edge line 3 coincides with its W1C: set wins
    wr(2'd2, 32'h4D);
    irq[3] = 1'b1;
    step(2);
    bus.reg_addr_i  = 2'd0;
    bus.reg_wdata_i = 32'h08;
    bus.reg_we_i    = 1'b1;
    #1;
    check("race_pre_write_rd", bus.reg_rdata_o, 32'h00);
    @(negedge clk);
    bus.reg_we_i = 1'b0;
    irq[3] = 1'b0;
    rd_check("race_set_wins", 2'd0, 32'h08);
    wr(2'd0, 32'h08);
    rd_check("race_clr_after", 2'd0, 32'h00);

    // Line 1 held high across reset release
    irq[1] = 1'b1;
    rst_n  = 1'b0;
    step(2);
    rst_n = 1'b1;
    wr(2'd2, 32'h02);
    step(2);
    rd_check("hold_rst_pend", 2'd0, 32'h02);
    wr(2'd1, 32'h02);
    step(1);
    check("hold_exp", 32'(exp_irq), 32'd1);
    check("hold_id", 32'(irq_id), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_exp", 32'(exp_irq), 32'd0);
    check("arst_id", 32'(irq_id), 32'd0);
    rd_check("arst_pend", 2'd0, 32'h0);
    rd_check("arst_claim", 2'd3, 32'h0);
    irq[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Claim read side effect (or its absence)
    wr(2'd2, 32'h11);
    wr(2'd1, 32'h11);
    irq[0] = 1'b1;
    irq[4] = 1'b1;
    step(3);
    irq[0] = 1'b0;
    irq[4] = 1'b0;
    rd_check("c_pend", 2'd0, 32'h11);
    bus.reg_addr_i = 2'd3;
    bus.reg_re_i   = 1'b1;
    #1;
    check("c_read1", bus.reg_rdata_o, 32'h8000_0000);
    @(negedge clk);
    bus.reg_re_i = 1'b0;
    #1;
`ifdef URV_IRQ_CTRL_CLAIM_CLEAR_EN
    check("c_read2", bus.reg_rdata_o, 32'h8000_0004);
    rd_check("c_pend2", 2'd0, 32'h10);
`else
    check("c_read2", bus.reg_rdata_o, 32'h8000_0000);
    rd_check("c_pend2", 2'd0, 32'h11);
`endif

    step(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
